branch_resolver: RTL

- Parametrised, registered successor to the control unit's combinational condition checker.
- Evaluates branch/jump conditions, computes the redirect target and drives the link-register write for JAL.
- Predicts JR targets with a circular return-address stack (RAS) and flags RAS mispredictions.
- Sits between ID/EX operand forwarding and PC-select logic; results are valid one cycle after issue.

---
 rtl/branch_resolver.sv | 96 +++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: registered branch/jump resolution with a circular return-address stack
module branch_resolver #(
    parameter int WORD_LEN  = 32,
    parameter int IMM_LEN   = 16,
    parameter int PC_INC    = 4,
    parameter int IMM_SHIFT = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [3:0]                     cond_sel,
    input  logic [WORD_LEN-1:0]            reg1,
    input  logic [WORD_LEN-1:0]            reg2,
    input  logic [IMM_LEN-1:0]             imm,
    input  logic [WORD_LEN-1:0]            pc_value,
    output logic                           br_valid,
    output logic                           br_taken,
    output logic [WORD_LEN-1:0]            br_target,
    output logic                           link_we,
    output logic [WORD_LEN-1:0]            link_value,
    output logic                           ras_pred_valid,
    output logic                           ras_mispredict,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] JUMP = 4'd1, JAL = 4'd2, JR = 4'd3, BEQ = 4'd4, BNE = 4'd5,
                           BLT = 4'd6, BLTU = 4'd7, BLTI = 4'd8, BLTIU = 4'd9;
    logic [WORD_LEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] ptr, top;
    logic [WORD_LEN-1:0] fall, sext_imm, zext_imm, target;
    logic taken, accept, push, pop, full, empty, is_branch;
    always_comb begin
        fall      = pc_value + WORD_LEN'(PC_INC);
        sext_imm  = {{(WORD_LEN-IMM_LEN){imm[IMM_LEN-1]}}, imm};
        zext_imm  = {{(WORD_LEN-IMM_LEN){1'b0}}, imm};
        is_branch = cond_sel >= BEQ && cond_sel <= BLTIU;
        taken     = (cond_sel == JUMP || cond_sel == JAL || cond_sel == JR) ? 1'b1 :
                    cond_sel == BEQ   ? reg1 == reg2 :
                    cond_sel == BNE   ? reg1 != reg2 :
                    cond_sel == BLT   ? $signed(reg1) < $signed(reg2) :
                    cond_sel == BLTU  ? reg1 < reg2 :
                    cond_sel == BLTI  ? $signed(reg1) < $signed(sext_imm) :
                    cond_sel == BLTIU ? reg1 < sext_imm : 1'b0;
        target    = (cond_sel == JUMP || cond_sel == JAL) ? zext_imm << IMM_SHIFT :
                    cond_sel == JR ? reg1 :
                    (is_branch && taken) ? fall + (sext_imm << IMM_SHIFT) : fall;
        accept    = valid_in && !stall && !flush;
        push      = accept && cond_sel == JAL;
        pop       = accept && cond_sel == JR;
        full      = ras_count == CW'(RAS_DEPTH);
        empty     = ras_count == '0;
        top       = ptr - PW'(1);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_valid       <= 1'b0;
            br_taken       <= 1'b0;
            br_target      <= '0;
            link_we        <= 1'b0;
            link_value     <= '0;
            ras_pred_valid <= 1'b0;
            ras_mispredict <= 1'b0;
            ras_count      <= '0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
            ptr            <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else if (!stall) begin
            br_valid       <= accept;
            br_taken       <= accept && taken;
            br_target      <= target;
            link_we        <= push;
            link_value     <= fall;
            ras_pred_valid <= pop && !empty;
            ras_mispredict <= pop && !empty && ras[top] != reg1;
            // A push while full lands on the oldest slot, since ptr has wrapped onto it
            if (push) begin
                ras[ptr]     <= fall;
                ptr          <= ptr + PW'(1);
                ras_count    <= full ? ras_count : ras_count + CW'(1);
                ras_overflow <= ras_overflow || full;
            end
            if (pop && !empty) begin
                ptr       <= top;
                ras_count <= ras_count - CW'(1);
            end
            if (pop && empty) ras_underflow <= 1'b1;
        end
    end
endmodule
